// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu - load/store unit for the single-cycle core.
//
// Takes the ALU result as the effective address and runs one data-memory
// transaction over a request/grant/response port. Stores are replicated across
// byte lanes with matching byte enables. Loads are shifted down to bit 0 and
// sign- or zero-extended. The core stalls while busy is high and resumes on the
// one-cycle done pulse. Misaligned or illegal-size accesses finish immediately
// with err set and never touch memory.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   lsu_en              start request (only looked at in IDLE)
//   lsu_we              1 = store, 0 = load
//   lsu_size            00 byte, 01 half, 10 word, 11 illegal
//   lsu_unsigned        loads: 1 zero-extend, 0 sign-extend
//   addr, wdata         effective address and store data
//   busy, done, err     stall, completion pulse, error flag (valid with done)
//   rdata               extended load result, held until the next load ends
//   mem_req/we/addr/be/wdata   memory request (held stable until mem_gnt)
//   mem_gnt             request accepted
//   mem_rvalid/rdata    load response (only looked at in WAIT)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module lsu #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lsu_en,
    input  logic          lsu_we,
    input  logic [1:0]    lsu_size,
    input  logic          lsu_unsigned,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    // Transaction attributes kept for the load-data path.
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;

    // Request-side decode of the incoming operation.
    logic [1:0]    off_in;
    logic          bad_in;
    logic [3:0]    be_in;
    logic [DW-1:0] wd_in;

    always_comb begin
        off_in = addr[1:0];
        bad_in = (lsu_size == 2'b11) ||
                 (lsu_size == 2'b01 && addr[0]) ||
                 (lsu_size == 2'b10 && addr[1:0] != 2'b00);
        case (lsu_size)
            2'b00: begin
                be_in = 4'b0001 << off_in;
                wd_in = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_in = 4'b0011 << off_in;
                wd_in = {2{wdata[15:0]}};
            end
            default: begin
                be_in = 4'b1111;
                wd_in = wdata;
            end
        endcase
    end

    // Load-data path: bring the addressed lane down to bit 0, then extend.
    logic [DW-1:0] shifted;
    logic [DW-1:0] ld_ext;

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'b0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ld_ext = uns_q ? {16'b0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_ext = shifted;
        endcase
    end

    // Next state and registered outputs. Pulse/level outputs default low each
    // cycle; the request payload and rdata hold unless explicitly loaded.
    always_comb begin
        state_d     = state_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;

        case (state_q)
            IDLE: begin
                if (lsu_en) begin
                    if (bad_in) begin
                        // Fault finishes at once; memory port is untouched.
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = REQ;
                        busy_d      = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = lsu_we;
                        mem_addr_d  = {addr[AW-1:2], 2'b00};
                        mem_be_d    = be_in;
                        mem_wdata_d = wd_in;
                        we_d        = lsu_we;
                        size_d      = lsu_size;
                        uns_d       = lsu_unsigned;
                        off_d       = off_in;
                    end
                end
            end
            REQ: begin
                busy_d    = 1'b1;
                mem_req_d = 1'b1;
                mem_we_d  = we_q;
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (we_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                if (mem_rvalid) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = ld_ext;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu - self-checking bench for lsu. A driver issues operations and plays
// the memory; expected completions go into a queue that a negedge monitor
// pops on every done pulse.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        lsu_en;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    lsu #(.DW(32), .AW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lsu_en       (lsu_en),
        .lsu_we       (lsu_we),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        expq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_rdata = 32'h0;
    logic [31:0] held        = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load result: pick the addressed lane, then extend.
    function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * off);
        if (size == 2'd0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest expected completion;
    // outside done, rdata must hold its last completed value.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = 32'h0;
        end else if (done) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done at %0t", $time);
            end else begin
                e = expq.pop_front();
                chk("done_err", {31'b0, err}, {31'b0, e.err});
                chk("done_rdata", rdata, e.rdata);
                chk("done_busy", {31'b0, busy}, 32'd0);
                held = e.rdata;
            end
        end else begin
            chk("rdata_hold", rdata, held);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation issued in the current cycle (cycle 0). gd/rd are the
    // number of cycles mem_gnt / mem_rvalid are withheld.
    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] word, input int gd, input int rd);
        exp_t        e;
        logic        bad;
        logic [1:0]  off;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        int          n;
        off = a[1:0];
        bad = (size == 2'd3) || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
        if (!bad && !we) model_rdata = exp_load(size, uns, off, word);
        e.err   = bad;
        e.rdata = model_rdata;
        expq.push_back(e);
        ebe = (size == 2'd0) ? 4'(1 << off) : (size == 2'd1) ? 4'(3 << off) : 4'hF;
        ewd = (size == 2'd0) ? {24'b0, wd[7:0]} * 32'h0101_0101 :
              (size == 2'd1) ? {16'b0, wd[15:0]} * 32'h0001_0001 : wd;

        lsu_en = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
        addr = a; wdata = wd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        step();
        // Inputs scrambled after issue: the request must be latched.
        lsu_en = 1'b0; addr = $urandom; wdata = $urandom;
        lsu_we = 1'($urandom); lsu_size = 2'($urandom); lsu_unsigned = 1'($urandom);
        if (bad) begin
            chk("err_no_req", {31'b0, mem_req}, 32'd0);
            chk("err_done_lat", {31'b0, done}, 32'd1);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                chk("req", {31'b0, mem_req}, 32'd1);
                chk("req_we", {31'b0, mem_we}, {31'b0, we});
                chk("req_addr", mem_addr, {a[31:2], 2'b00});
                chk("req_be", {28'b0, mem_be}, {28'b0, ebe});
                if (we) chk("req_wdata", mem_wdata, ewd);
                chk("req_busy", {31'b0, busy}, 32'd1);
                lsu_en     = 1'($urandom);
                mem_gnt    = (i == gd);
                mem_rvalid = 1'($urandom);   // ignored in REQ and in the grant cycle
                mem_rdata  = $urandom;
                step();
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0; lsu_en = 1'b0;
            if (!we) begin
                chk("req_drop", {31'b0, mem_req}, 32'd0);
                for (int i = 0; i <= rd; i++) begin
                    chk("wait_busy", {31'b0, busy}, 32'd1);
                    mem_rvalid = (i == rd);
                    mem_rdata  = (i == rd) ? word : $urandom;
                    lsu_en     = 1'($urandom);
                    step();
                end
                mem_rvalid = 1'b0; lsu_en = 1'b0;
            end
            chk("done_lat", {31'b0, done}, 32'd1);
            chk("done_req", {31'b0, mem_req}, 32'd0);
        end
        n = 0;
        while (!done && n < 8) begin
            step();
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 required=1 at %0t", $time);
        end
        // DONE cycle: a new request here must be ignored.
        lsu_en = 1'($urandom); lsu_we = 1'($urandom); lsu_size = 2'($urandom);
        addr = $urandom & 32'hFFFF_FFFC;
        step();
        lsu_en = 1'b0;
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_req", {31'b0, mem_req}, 32'd0);
        // Stray response in IDLE must be ignored.
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        step();
        mem_rvalid = 1'b0;
        chk("stray_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_req"}, {31'b0, mem_req}, 32'd0);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_be"}, {28'b0, mem_be}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] sz;
        rst_n = 1'b0; lsu_en = 1'b0; lsu_we = 1'b0; lsu_size = 2'd0; lsu_unsigned = 1'b0;
        addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset_vals("rst");
        step();

        // Directed cases
        do_op(1'b0, 2'd2, 1'b0, 32'h1000_0008, 32'h0, 32'hDEAD_BEEF, 0, 0);   // LW
        do_op(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, 32'h8012_3456, 0, 0);   // LB
        do_op(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 32'h8012_3456, 1, 2);   // LBU
        do_op(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 32'h0, 3, 0);   // SH
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0, 0);           // LW misaligned
        do_op(1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0, 0);           // LH misaligned
        do_op(1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0, 0);           // illegal size
        do_op(1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0, 1);   // LH upper half

        // Reset while waiting for load data, then a late response.
        lsu_en = 1'b1; lsu_we = 1'b0; lsu_size = 2'd2; lsu_unsigned = 1'b0;
        addr = 32'h0000_0040;
        step();
        lsu_en = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("wait_busy_pre_rst", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_rdata = 32'h0;
        chk_reset_vals("midrst");
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        chk_reset_vals("late_rv");
        do_op(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 0);

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_op(1'($urandom), sz, 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~(32'hFFFF_FFFF << sz)) ^ $urandom & 32'hFFFF_FFFC,
                  $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (3) step();
        chk("queue_empty", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
